branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit bimodal counters, sitting beside the fetch stage and directly downstream of the execute-stage branch resolver. It predicts the next PC for each fetched PC one cycle after lookup, and trains on the resolver's per-branch outcome (taken flag and next PC). It also detects mispredictions and issues a registered redirect/flush to fetch.

---
 rtl/branch_predictor_if.sv | 82 ++++++++
 rtl/branch_predictor.sv | 201 ++++++++++++++++++++
 tb/tb_branch_predictor.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if
//
// Purpose:
//   Groups the fetch-side lookup, the prediction result, the resolver training
//   bus and the redirect/flush output of the branch predictor into one bundle.
//   Clock and reset are not part of the bundle.
//
// Signals:
//   stall          fetch -> predictor   hold the prediction output registers
//   fetchValid     fetch -> predictor   fetchPc is a real lookup this cycle
//   fetchPc        fetch -> predictor   PC being fetched
//   predValid      predictor -> fetch   prediction outputs valid
//   predPc         predictor -> fetch   echo of the looked-up PC
//   predTaken      predictor -> fetch   predicted taken
//   predNextPc     predictor -> fetch   predicted next PC
//   updValid       resolver -> predictor  resolver result valid this cycle
//   updIsBranch    resolver -> predictor  instruction is a branch/jump
//   updPc          resolver -> predictor  PC of the resolved instruction
//   updTaken       resolver -> predictor  resolved taken flag
//   updNextPc      resolver -> predictor  resolved next PC
//   updPredNextPc  resolver -> predictor  prediction carried down the pipe
//   redirectValid  predictor -> fetch   mispredict flush pulse
//   redirectPc     predictor -> fetch   correct fetch PC
//
// Modports:
//   master  the pipeline side (fetch + resolver) that drives lookups/updates
//   slave   the predictor itself
// ----------------------------------------------------------------------------
interface branch_predictor_if;
    logic        stall;
    logic        fetchValid;
    logic [31:0] fetchPc;
    logic        predValid;
    logic [31:0] predPc;
    logic        predTaken;
    logic [31:0] predNextPc;
    logic        updValid;
    logic        updIsBranch;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updNextPc;
    logic [31:0] updPredNextPc;
    logic        redirectValid;
    logic [31:0] redirectPc;

    modport master (
        output stall,
        output fetchValid,
        output fetchPc,
        input  predValid,
        input  predPc,
        input  predTaken,
        input  predNextPc,
        output updValid,
        output updIsBranch,
        output updPc,
        output updTaken,
        output updNextPc,
        output updPredNextPc,
        input  redirectValid,
        input  redirectPc
    );

    modport slave (
        input  stall,
        input  fetchValid,
        input  fetchPc,
        output predValid,
        output predPc,
        output predTaken,
        output predNextPc,
        input  updValid,
        input  updIsBranch,
        input  updPc,
        input  updTaken,
        input  updNextPc,
        input  updPredNextPc,
        output redirectValid,
        output redirectPc
    );
endinterface

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Purpose:
//   Direct-mapped branch target buffer with a 2-bit bimodal counter per entry.
//   Each fetched PC is looked up and a registered next-PC prediction appears
//   one cycle later. The execute-stage resolver trains the table with the real
//   outcome of every branch, and any branch whose real next PC differs from the
//   prediction carried down the pipe raises a registered one-cycle redirect.
//
// Parameters:
//   ENTRY_NUM    number of BTB entries (power of two, at least 2)
//   INDEX_WIDTH  index bits, taken from PC[INDEX_WIDTH+1:2]
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rstN  asynchronous active-low reset
//   bus   branch_predictor_if.slave (lookup, prediction, training, redirect)
//
// Entry layout: valid, tag = PC[31:INDEX_WIDTH+2], target[31:0], ctr[1:0].
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRY_NUM   = 64,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic              clk,
    input  logic              rstN,
    branch_predictor_if.slave bus
);

    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    // Counter value given to a freshly allocated entry (weakly taken) and the
    // value every counter resets to (weakly not taken).
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_RESET = 2'b01;

    // ------------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------------
    logic                 entryValid_q  [ENTRY_NUM];
    logic [TAG_WIDTH-1:0] entryTag_q    [ENTRY_NUM];
    logic [31:0]          entryTarget_q [ENTRY_NUM];
    logic [1:0]           entryCtr_q    [ENTRY_NUM];

    // ------------------------------------------------------------------------
    // Prediction and redirect output registers
    // ------------------------------------------------------------------------
    logic        predValid_q,     predValid_d;
    logic [31:0] predPc_q,        predPc_d;
    logic        predTaken_q,     predTaken_d;
    logic [31:0] predNextPc_q,    predNextPc_d;
    logic        redirectValid_q, redirectValid_d;
    logic [31:0] redirectPc_q,    redirectPc_d;

    // ------------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] fetchIndex;
    logic [TAG_WIDTH-1:0]   fetchTag;
    logic                   lookupHit;
    logic                   lookupTaken;
    logic [31:0]            lookupNextPc;

    // ------------------------------------------------------------------------
    // Training path
    // ------------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] updIndex;
    logic [TAG_WIDTH-1:0]   updTag;
    logic                   updHit;
    logic                   updTrain;
    logic                   mispredict;
    logic                   tableWe;
    logic [TAG_WIDTH-1:0]   entryTag_d;
    logic [31:0]            entryTarget_d;
    logic [1:0]             entryCtr_d;

    // Byte-offset bits of the PCs carry no information for a word-aligned
    // table; they are collected here so the intent is explicit.
    logic unusedPcBits;
    assign unusedPcBits = ^{bus.fetchPc[1:0], bus.updPc[1:0]};

    assign fetchIndex = bus.fetchPc[INDEX_WIDTH+1:2];
    assign fetchTag   = bus.fetchPc[31:INDEX_WIDTH+2];
    assign updIndex   = bus.updPc[INDEX_WIDTH+1:2];
    assign updTag     = bus.updPc[31:INDEX_WIDTH+2];

    // Lookup reads the registered table contents, so an update to the same
    // index in this cycle is only seen by lookups issued from the next cycle.
    always_comb begin
        lookupHit    = entryValid_q[fetchIndex] && (entryTag_q[fetchIndex] == fetchTag);
        lookupTaken  = lookupHit && entryCtr_q[fetchIndex][1];
        lookupNextPc = lookupTaken ? entryTarget_q[fetchIndex] : (bus.fetchPc + 32'd4);
    end

    // Only real branches train or mispredict; a non-branch that slips through
    // with updValid set is ignored entirely.
    always_comb begin
        updTrain   = bus.updValid && bus.updIsBranch;
        updHit     = entryValid_q[updIndex] && (entryTag_q[updIndex] == updTag);
        mispredict = updTrain && (bus.updNextPc != bus.updPredNextPc);
    end

    // Next contents of the entry addressed by the resolver. A hit nudges the
    // saturating counter toward the outcome and refreshes the target on taken;
    // a taken miss claims the slot outright, evicting whatever aliased there;
    // a not-taken miss leaves the table alone so it cannot evict a useful
    // entry that merely shares the index.
    always_comb begin
        tableWe       = 1'b0;
        entryTag_d    = updTag;
        entryTarget_d = entryTarget_q[updIndex];
        entryCtr_d    = entryCtr_q[updIndex];
        if (updTrain) begin
            if (updHit) begin
                tableWe = 1'b1;
                if (bus.updTaken) begin
                    entryTarget_d = bus.updNextPc;
                    if (entryCtr_q[updIndex] != 2'b11) begin
                        entryCtr_d = entryCtr_q[updIndex] + 2'd1;
                    end
                end else begin
                    if (entryCtr_q[updIndex] != 2'b00) begin
                        entryCtr_d = entryCtr_q[updIndex] - 2'd1;
                    end
                end
            end else if (bus.updTaken) begin
                tableWe       = 1'b1;
                entryTarget_d = bus.updNextPc;
                entryCtr_d    = CTR_ALLOC;
            end
        end
    end

    // Table update. Training runs regardless of stall or mispredict so the
    // resolver's outcome is never lost.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entryValid_q[i]  <= 1'b0;
                entryTag_q[i]    <= '0;
                entryTarget_q[i] <= '0;
                entryCtr_q[i]    <= CTR_RESET;
            end
        end else if (tableWe) begin
            entryValid_q[updIndex]  <= 1'b1;
            entryTag_q[updIndex]    <= entryTag_d;
            entryTarget_q[updIndex] <= entryTarget_d;
            entryCtr_q[updIndex]    <= entryCtr_d;
        end
    end

    // Prediction outputs freeze while fetch is stalled. A lookup issued in the
    // same cycle as a mispredict belongs to the wrong path and is dropped.
    always_comb begin
        predValid_d  = predValid_q;
        predPc_d     = predPc_q;
        predTaken_d  = predTaken_q;
        predNextPc_d = predNextPc_q;
        if (!bus.stall) begin
            predValid_d  = bus.fetchValid && !mispredict;
            predPc_d     = bus.fetchPc;
            predTaken_d  = lookupTaken;
            predNextPc_d = lookupNextPc;
        end
    end

    // Redirect is a single-cycle pulse per mispredicting update; the target
    // stays put between pulses so fetch may sample it late.
    always_comb begin
        redirectValid_d = mispredict;
        redirectPc_d    = mispredict ? bus.updNextPc : redirectPc_q;
    end

    // Output registers; reset clears any in-flight redirect immediately.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            predValid_q     <= 1'b0;
            predPc_q        <= '0;
            predTaken_q     <= 1'b0;
            predNextPc_q    <= '0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
        end else begin
            predValid_q     <= predValid_d;
            predPc_q        <= predPc_d;
            predTaken_q     <= predTaken_d;
            predNextPc_q    <= predNextPc_d;
            redirectValid_q <= redirectValid_d;
            redirectPc_q    <= redirectPc_d;
        end
    end

    assign bus.predValid     = predValid_q;
    assign bus.predPc        = predPc_q;
    assign bus.predTaken     = predTaken_q;
    assign bus.predNextPc    = predNextPc_q;
    assign bus.redirectValid = redirectValid_q;
    assign bus.redirectPc    = redirectPc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//
// Purpose:
//   Directed bench for branch_predictor (ENTRY_NUM = 64, so PC[7:2] indexes
//   the table and every multiple of 0x100 shares index 0). Stimulus pushes the
//   hand-computed expected prediction / redirect into queues; a monitor pops
//   and compares whenever the DUT presents a fresh prediction or a redirect.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] nextPc;
    } predExp_t;

    logic clk;
    logic rstN;

    int vectorCount = 0;
    int missCount   = 0;

    predExp_t    predQ  [$];
    logic [31:0] redirQ [$];

    branch_predictor_if bus ();

    branch_predictor #(
        .ENTRY_NUM (64)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every input for one cycle; inputs change on the falling edge so
    // the rising edge in between sees stable values.
    task automatic applyStimulus(
        input logic        st,
        input logic        fv,
        input logic [31:0] fpc,
        input logic        uv,
        input logic        ub,
        input logic [31:0] upc,
        input logic        ut,
        input logic [31:0] unext,
        input logic [31:0] upred
    );
        bus.stall         = st;
        bus.fetchValid    = fv;
        bus.fetchPc       = fpc;
        bus.updValid      = uv;
        bus.updIsBranch   = ub;
        bus.updPc         = upc;
        bus.updTaken      = ut;
        bus.updNextPc     = unext;
        bus.updPredNextPc = upred;
        @(negedge clk);
    endtask

    task automatic idleInputs();
        bus.stall         = 1'b0;
        bus.fetchValid    = 1'b0;
        bus.fetchPc       = '0;
        bus.updValid      = 1'b0;
        bus.updIsBranch   = 1'b0;
        bus.updPc         = '0;
        bus.updTaken      = 1'b0;
        bus.updNextPc     = '0;
        bus.updPredNextPc = '0;
    endtask

    task automatic expectPred(input logic [31:0] pc, input logic taken, input logic [31:0] nextPc);
        predExp_t e;
        e.pc     = pc;
        e.taken  = taken;
        e.nextPc = nextPc;
        predQ.push_back(e);
    endtask

    task automatic expectRedirect(input logic [31:0] pc);
        redirQ.push_back(pc);
    endtask

    // Direct snapshot of every output against hand-computed values.
    task automatic checkOutput(
        input string       name,
        input logic        expValid,
        input logic [31:0] expPc,
        input logic        expTaken,
        input logic [31:0] expNext,
        input logic        expRedir,
        input logic [31:0] expRedirPc
    );
        logic [98:0] got;
        logic [98:0] want;
        got  = {bus.predValid, bus.predPc, bus.predTaken, bus.predNextPc,
                bus.redirectValid, bus.redirectPc};
        want = {expValid, expPc, expTaken, expNext, expRedir, expRedirPc};
        vectorCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got v=%b pc=%h t=%b np=%h rv=%b rpc=%h, want v=%b pc=%h t=%b np=%h rv=%b rpc=%h",
                     name, got[98], got[97:66], got[65], got[64:33], got[32], got[31:0],
                     expValid, expPc, expTaken, expNext, expRedir, expRedirPc);
        end
    endtask

    // Monitor: a prediction is fresh when predValid is high after an edge
    // where stall was low; every redirect pulse is consumed as well.
    initial begin : monitor
        logic stallAtEdge;
        logic rstAtEdge;
        predExp_t e;
        logic [31:0] rpc;
        forever begin
            @(posedge clk);
            stallAtEdge = bus.stall;
            rstAtEdge   = rstN;
            #1;
            if (rstN && rstAtEdge) begin
                if (bus.predValid && !stallAtEdge) begin
                    vectorCount++;
                    if (predQ.size() == 0) begin
                        missCount++;
                        $display("[TB] FAIL pred unexpected: got pc=%h t=%b np=%h, want no prediction",
                                 bus.predPc, bus.predTaken, bus.predNextPc);
                    end else begin
                        e = predQ.pop_front();
                        if (bus.predPc !== e.pc || bus.predTaken !== e.taken || bus.predNextPc !== e.nextPc) begin
                            missCount++;
                            $display("[TB] FAIL pred: got pc=%h t=%b np=%h, want pc=%h t=%b np=%h",
                                     bus.predPc, bus.predTaken, bus.predNextPc, e.pc, e.taken, e.nextPc);
                        end
                    end
                end
                if (bus.redirectValid) begin
                    vectorCount++;
                    if (redirQ.size() == 0) begin
                        missCount++;
                        $display("[TB] FAIL redirect unexpected: got rpc=%h, want no redirect", bus.redirectPc);
                    end else begin
                        rpc = redirQ.pop_front();
                        if (bus.redirectPc !== rpc) begin
                            missCount++;
                            $display("[TB] FAIL redirect: got rpc=%h, want rpc=%h", bus.redirectPc, rpc);
                        end
                    end
                end
            end
        end
    end

    // Directed sequence. Comments track the counter of the 0x100 entry.
    initial begin : stimulus
        idleInputs();
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1 checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Cold lookup misses.
        expectPred(32'h100, 1'b0, 32'h104);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        // Taken miss allocates ctr=2, target 0x200; mispredict.
        expectRedirect(32'h200);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h200, 32'h104);
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        // Not taken after predicting 0x200: ctr 2->1, redirect to 0x104.
        expectRedirect(32'h104);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h104, 32'h200);
        // Lookup sees ctr=1; correctly predicted not-taken update ctr 1->0.
        expectPred(32'h100, 1'b0, 32'h104);
        applyStimulus(0, 1, 32'h100, 1, 1, 32'h100, 0, 32'h104, 32'h104);
        // ctr stays at 0.
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h104, 32'h104);
        expectPred(32'h100, 1'b0, 32'h104);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        // Taken: ctr 0->1, still predicted not taken.
        expectRedirect(32'h200);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h200, 32'h104);
        expectPred(32'h100, 1'b0, 32'h104);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        // Back-to-back mispredicts: ctr 1->2->3.
        expectRedirect(32'h200);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h200, 32'h104);
        expectRedirect(32'h200);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h200, 32'h104);
        // Saturate at 3, then not taken brings it to 2.
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 1, 32'h200, 32'h200);
        expectRedirect(32'h104);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h104, 32'h200);
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);

        // Alias at 0x100 + 4*64 misses; not-taken update there changes nothing.
        expectPred(32'h200, 1'b0, 32'h204);
        applyStimulus(0, 1, 32'h200, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h204, 32'h204);
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);

        // Non-branch: no redirect, no kill, no training.
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 1, 0, 32'h100, 1, 32'h999C, 32'h0);
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);

        // Lookup in the mispredict cycle is killed; 0x40 gets allocated.
        expectRedirect(32'h80);
        applyStimulus(0, 1, 32'h100, 1, 1, 32'h40,  1, 32'h80,  32'h44);
        expectPred(32'h40, 1'b1, 32'h80);
        applyStimulus(0, 1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   32'h0);

        // Stall freezes outputs while training and redirect continue.
        expectPred(32'h44, 1'b0, 32'h48);
        applyStimulus(0, 1, 32'h44,  0, 0, 32'h0,   0, 32'h0,   32'h0);
        expectRedirect(32'h1000);
        applyStimulus(1, 1, 32'h40,  1, 1, 32'h48,  1, 32'h1000, 32'h4C);
        checkOutput("stallFreeze", 1'b1, 32'h44, 1'b0, 32'h48, 1'b1, 32'h1000);
        expectPred(32'h48, 1'b1, 32'h1000);
        applyStimulus(0, 1, 32'h48,  0, 0, 32'h0,   0, 32'h0,   32'h0);
        checkOutput("redirectHold", 1'b1, 32'h48, 1'b1, 32'h1000, 1'b0, 32'h1000);

        // Same-cycle lookup and update of 0x100 (ctr 2->3, target 0x300).
        expectPred(32'h100, 1'b1, 32'h200);
        applyStimulus(0, 1, 32'h100, 1, 1, 32'h100, 1, 32'h300, 32'h300);
        expectPred(32'h100, 1'b1, 32'h300);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);

        // PC+4 wraps to zero.
        expectPred(32'hFFFF_FFFC, 1'b0, 32'h0);
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 32'h0);

        // Reset in the middle of a redirect pulse.
        expectRedirect(32'h44);
        applyStimulus(0, 0, 32'h0,   1, 1, 32'h40,  0, 32'h44,  32'h80);
        idleInputs();
        rstN = 1'b0;
        #1 checkOutput("resetMidRedirect", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Table contents were cleared by reset.
        expectPred(32'h100, 1'b0, 32'h104);
        applyStimulus(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        expectPred(32'h40, 1'b0, 32'h44);
        applyStimulus(0, 1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   32'h0);

        idleInputs();
        repeat (3) @(negedge clk);

        vectorCount++;
        if (predQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL predDrain: got %0d predictions outstanding, want 0", predQ.size());
        end
        vectorCount++;
        if (redirQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL redirectDrain: got %0d redirects outstanding, want 0", redirQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
